// File: rtl/int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_ctrl_pkg
//   Shared constants for the interrupt controller: number of interrupt lines,
//   bus register word offsets, FSM state encoding and the fixed-priority
//   selector used to pick the line presented to CP0.
// -----------------------------------------------------------------------------
package int_ctrl_pkg;

   localparam int NUM_IRQ = 6;

   typedef logic [NUM_IRQ-1:0] irq_vec_t;

   // Bus register word offsets
   localparam logic [1:0] OFF_MODE = 2'd0;
   localparam logic [1:0] OFF_MASK = 2'd1;
   localparam logic [1:0] OFF_PEND = 2'd2;
   localparam logic [1:0] OFF_EOI  = 2'd3;   // write: end of interrupt, read: status

   // FSM state encoding (visible to software through the status register)
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ASSERT  = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   // One-hot of the highest-index set bit; zero when no bit is set.
   function automatic irq_vec_t prio_onehot(input irq_vec_t req);
      irq_vec_t sel;
      logic     found;
      sel   = '0;
      found = 1'b0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i] && !found) begin
            sel[i] = 1'b1;
            found  = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/int_ctrl_irq_sync.sv
// -----------------------------------------------------------------------------
// irq_sync
//   Synchronizer chain for one asynchronous interrupt line plus a rising-edge
//   detector on the synchronized level.
//
// Ports
//   clk    in   clock
//   reset  in   asynchronous active-low reset
//   irq    in   raw interrupt line, asynchronous to clk
//   lvl    out  synchronized level (output of the last chain flop)
//   rise   out  high for the one cycle where lvl has just gone 0 -> 1
// -----------------------------------------------------------------------------
module irq_sync #(
   parameter int unsigned STAGES = 2   // legal range 2..3
) (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   output logic lvl,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              lvl_prev_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q     <= '0;
         lvl_prev_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[STAGES-2:0], irq};
         lvl_prev_q <= sync_q[STAGES-1];
      end
   end

   assign lvl  = sync_q[STAGES-1];
   assign rise = lvl & ~lvl_prev_q;

endmodule

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
//   Six-line interrupt controller in front of CP0. Each raw line is
//   synchronized; lines are either level- or edge-triggered (MODE), gated by
//   MASK and by the in-service register, and the highest-index deliverable
//   line is presented one-hot on hw_int. CP0 accepts with int_take, software
//   finishes with a write to the EOI offset. No nesting: nothing is presented
//   while an interrupt is in service.
//
// Ports
//   clk       in   1   clock, rising edge
//   reset     in   1   asynchronous active-low reset
//   irq_in    in   6   raw device interrupt lines
//   we        in   1   bus write enable
//   addr      in   2   word offset: 0 MODE, 1 MASK, 2 PEND (W1C), 3 EOI/STAT
//   wdata     in   32  bus write data, bits [5:0] used
//   rdata     out  32  combinational read of the register at addr
//   int_take  in   1   one-cycle accept pulse from CP0
//   hw_int    out  6   registered one-hot interrupt vector to CP0
// -----------------------------------------------------------------------------
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2   // legal range 2..3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  irq_in,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        int_take,
   output logic [5:0]  hw_int
);

   // ---------------------------------------------------------------------------
   // Synchronizers and edge detectors
   // ---------------------------------------------------------------------------
   irq_vec_t lvl;
   irq_vec_t rise;

   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
      irq_sync #(
         .STAGES (SYNC_STAGES)
      ) u_irq_sync (
         .clk   (clk),
         .reset (reset),
         .irq   (irq_in[i]),
         .lvl   (lvl[i]),
         .rise  (rise[i])
      );
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   irq_vec_t   mode_q, mode_d;
   irq_vec_t   mask_q, mask_d;
   irq_vec_t   pend_q, pend_d;
   irq_vec_t   isr_q, isr_d;
   irq_vec_t   hw_int_q, hw_int_d;
   logic [1:0] state_q, state_d;

   // Only the low bits of wdata carry register content.
   logic unused_wdata_hi;
   assign unused_wdata_hi = ^wdata[31:NUM_IRQ];

   // ---------------------------------------------------------------------------
   // Bus write decode
   // ---------------------------------------------------------------------------
   logic     wr_mode, wr_mask, wr_pend, wr_eoi;
   irq_vec_t wbits;

   assign wr_mode = we && (addr == OFF_MODE);
   assign wr_mask = we && (addr == OFF_MASK);
   assign wr_pend = we && (addr == OFF_PEND);
   assign wr_eoi  = we && (addr == OFF_EOI);
   assign wbits   = wdata[NUM_IRQ-1:0];

   // ---------------------------------------------------------------------------
   // Deliverable lines and priority select
   // ---------------------------------------------------------------------------
   irq_vec_t deliverable;
   irq_vec_t sel;
   logic     any_deliv;

   // Edge lines are served from PEND, level lines straight from the
   // synchronized input; ISR blocks a line that is already being serviced.
   assign deliverable = mask_q & ~isr_q & ((mode_q & pend_q) | (~mode_q & lvl));
   assign sel         = prio_onehot(deliverable);
   assign any_deliv   = |deliverable;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      mode_d   = mode_q;
      mask_d   = mask_q;
      pend_d   = pend_q;
      isr_d    = isr_q;
      hw_int_d = hw_int_q;
      state_d  = state_q;

      if (wr_mode) begin
         mode_d = wbits;
      end
      if (wr_mask) begin
         mask_d = wbits;
      end
      if (wr_pend) begin
         pend_d = pend_d & ~wbits;
      end

      case (state_q)
         ST_IDLE: begin
            hw_int_d = sel;
            if (any_deliv) begin
               state_d = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            if (int_take) begin
               // Latch what CP0 actually saw, not a same-cycle priority change.
               isr_d    = hw_int_q;
               pend_d   = pend_d & ~hw_int_q;
               hw_int_d = '0;
               state_d  = ST_SERVICE;
            end else if (any_deliv) begin
               hw_int_d = sel;
            end else begin
               hw_int_d = '0;
               state_d  = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            hw_int_d = '0;
            if (wr_eoi) begin
               isr_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            hw_int_d = '0;
            isr_d    = '0;
            state_d  = ST_IDLE;
         end
      endcase

      // Applied last so a new edge survives a same-cycle W1C or take clear.
      pend_d = pend_d | (rise & mode_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q   <= '0;
         mask_q   <= '0;
         pend_q   <= '0;
         isr_q    <= '0;
         hw_int_q <= '0;
         state_q  <= ST_IDLE;
      end else begin
         mode_q   <= mode_d;
         mask_q   <= mask_d;
         pend_q   <= pend_d;
         isr_q    <= isr_d;
         hw_int_q <= hw_int_d;
         state_q  <= state_d;
      end
   end

   assign hw_int = hw_int_q;

   // ---------------------------------------------------------------------------
   // Register read
   // ---------------------------------------------------------------------------
   always_comb begin
      rdata = '0;
      case (addr)
         OFF_MODE: rdata[NUM_IRQ-1:0] = mode_q;
         OFF_MASK: rdata[NUM_IRQ-1:0] = mask_q;
         OFF_PEND: rdata[NUM_IRQ-1:0] = pend_q;
         default: begin
            rdata[NUM_IRQ-1:0] = lvl;
            rdata[13:8]        = isr_q;
            rdata[17:16]       = state_q;
         end
      endcase
   end

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl
//   Bench for int_ctrl: directed scenarios with literal expectations, then a
//   randomized run checked every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

   localparam int SS = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  irq_in;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        int_take;
   logic [5:0]  hw_int;

   int total = 0;
   int bad   = 0;

   int_ctrl #(
      .SYNC_STAGES (SS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .irq_in   (irq_in),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .int_take (int_take),
      .hw_int   (hw_int)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Behavioural model
   //   m_samp[k] is irq_in as sampled k+1 rising edges ago, so the
   //   synchronized level is simply the input delayed by SS samples and an
   //   edge is "delayed sample high, the one before it low".
   // ---------------------------------------------------------------------------
   logic [5:0] m_mode = '0;
   logic [5:0] m_mask = '0;
   logic [5:0] m_pend = '0;
   logic [5:0] m_isr  = '0;
   logic [5:0] m_hw   = '0;
   int         m_st   = 0;   // 0 idle, 1 presenting, 2 in service
   logic [5:0] m_samp [0:SS];

   function automatic logic [5:0] top_one(input logic [5:0] v);
      logic [5:0] r;
      r = '0;
      for (int i = 5; i >= 0; i--) begin
         if (v[i]) begin
            r[i] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         2'd0: r[5:0] = m_mode;
         2'd1: r[5:0] = m_mask;
         2'd2: r[5:0] = m_pend;
         default: begin
            r[5:0]   = m_samp[SS-1];
            r[13:8]  = m_isr;
            r[17:16] = 2'(m_st);
         end
      endcase
      return r;
   endfunction

   task automatic model_clear();
      m_mode = '0;
      m_mask = '0;
      m_pend = '0;
      m_isr  = '0;
      m_hw   = '0;
      m_st   = 0;
      for (int k = 0; k <= SS; k++) m_samp[k] = '0;
   endtask

   task automatic model_step();
      logic [5:0] lv, rs, dl, sl, n_mode, n_mask, n_pend, n_isr, n_hw;
      int         n_st;
      lv = m_samp[SS-1];
      rs = lv & ~m_samp[SS];
      dl = '0;
      for (int i = 0; i < 6; i++) begin
         if (m_mask[i] && !m_isr[i] && (m_mode[i] ? m_pend[i] : lv[i])) dl[i] = 1'b1;
      end
      sl     = top_one(dl);
      n_mode = m_mode;
      n_mask = m_mask;
      n_pend = m_pend;
      n_isr  = m_isr;
      n_hw   = m_hw;
      n_st   = m_st;
      if (we && addr == 2'd0) n_mode = wdata[5:0];
      if (we && addr == 2'd1) n_mask = wdata[5:0];
      if (we && addr == 2'd2) n_pend = n_pend & ~wdata[5:0];
      if (m_st == 0) begin
         n_hw = sl;
         if (dl != 0) n_st = 1;
      end else if (m_st == 1) begin
         if (int_take) begin
            n_isr  = m_hw;
            n_pend = n_pend & ~m_hw;
            n_hw   = '0;
            n_st   = 2;
         end else if (dl != 0) begin
            n_hw = sl;
         end else begin
            n_hw = '0;
            n_st = 0;
         end
      end else begin
         n_hw = '0;
         if (we && addr == 2'd3) begin
            n_isr = '0;
            n_st  = 0;
         end
      end
      n_pend = n_pend | (rs & m_mode);
      for (int k = SS; k > 0; k--) m_samp[k] = m_samp[k-1];
      m_samp[0] = irq_in;
      m_mode = n_mode;
      m_mask = n_mask;
      m_pend = n_pend;
      m_isr  = n_isr;
      m_hw   = n_hw;
      m_st   = n_st;
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_clear();
         else model_step();
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         total++;
         if (hw_int !== m_hw) begin
            bad++;
            $display("FAIL cyc_hw_int t=%0t: got %h expected %h", $time, hw_int, m_hw);
         end
         total++;
         if (rdata !== m_read(addr)) begin
            bad++;
            $display("FAIL cyc_rdata[%0d] t=%0t: got %h expected %h", addr, $time, rdata,
                     m_read(addr));
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (all drives happen 1 time unit after a rising edge)
   // ---------------------------------------------------------------------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      we    = 1'b1;
      addr  = a;
      wdata = d;
      tick(1);
      we    = 1'b0;
   endtask

   task automatic take();
      int_take = 1'b1;
      tick(1);
      int_take = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(name, rdata, exp);
   endtask

   // ---------------------------------------------------------------------------
   // Directed scenarios, then randomized traffic
   // ---------------------------------------------------------------------------
   initial begin
      reset    = 1'b0;
      irq_in   = '0;
      we       = 1'b0;
      addr     = '0;
      wdata    = '0;
      int_take = 1'b0;
      #23;
      reset = 1'b1;
      tick(1);

      // Reset state
      rd_chk("rst_mode", 2'd0, 32'h0);
      rd_chk("rst_mask", 2'd1, 32'h0);
      rd_chk("rst_pend", 2'd2, 32'h0);
      rd_chk("rst_stat", 2'd3, 32'h0);
      chk("rst_hw", 32'(hw_int), 32'h0);

      // Level line 0: two edges of sync, one more to present
      wr(2'd1, 32'h01);
      irq_in[0] = 1'b1;
      tick(2);
      chk("lvl_latency_hw", 32'(hw_int), 32'h00);
      tick(1);
      chk("lvl_hw", 32'(hw_int), 32'h01);
      take();
      chk("lvl_take_hw", 32'(hw_int), 32'h00);
      rd_chk("lvl_take_stat", 2'd3, 32'h0002_0101);
      irq_in = '0;
      tick(3);
      wr(2'd3, 32'h0);
      rd_chk("lvl_eoi_stat", 2'd3, 32'h0);

      // Two edge lines, higher index wins
      wr(2'd1, 32'h3F);
      wr(2'd0, 32'h3F);
      irq_in = 6'h02;
      tick(1);
      irq_in = 6'h10;
      tick(1);
      irq_in = '0;
      tick(3);
      rd_chk("edge_pend", 2'd2, 32'h12);
      chk("edge_hw_first", 32'(hw_int), 32'h10);
      take();
      rd_chk("edge_take_stat", 2'd3, 32'h0002_1000);
      rd_chk("edge_take_pend", 2'd2, 32'h02);
      wr(2'd3, 32'h0);
      tick(1);
      chk("edge_hw_second", 32'(hw_int), 32'h02);
      take();
      wr(2'd3, 32'h0);
      rd_chk("edge_pend_empty", 2'd2, 32'h0);

      // Higher-priority level arrival while presenting, then re-delivery
      wr(2'd0, 32'h0);
      wr(2'd1, 32'h24);
      irq_in[2] = 1'b1;
      tick(3);
      chk("pre_hw_04", 32'(hw_int), 32'h04);
      irq_in[5] = 1'b1;
      tick(2);
      chk("pre_hw_still_04", 32'(hw_int), 32'h04);
      tick(1);
      chk("pre_hw_20", 32'(hw_int), 32'h20);
      take();
      rd_chk("pre_take_stat", 2'd3, 32'h0002_2024);
      irq_in[5] = 1'b0;
      tick(3);
      wr(2'd3, 32'h0);
      rd_chk("redeliver_idle", 2'd3, 32'h0000_0004);
      tick(1);
      chk("redeliver_hw", 32'(hw_int), 32'h04);
      rd_chk("redeliver_assert", 2'd3, 32'h0001_0004);
      wr(2'd1, 32'h0);
      tick(1);
      chk("mask_drop_hw", 32'(hw_int), 32'h00);
      rd_chk("mask_drop_stat", 2'd3, 32'h0000_0004);
      irq_in = '0;
      tick(3);

      // Same-cycle edge set beats W1C
      wr(2'd0, 32'h08);
      irq_in[3] = 1'b1;
      tick(2);
      wr(2'd2, 32'h08);
      rd_chk("w1c_vs_edge", 2'd2, 32'h08);
      wr(2'd2, 32'h08);
      rd_chk("w1c_clear", 2'd2, 32'h00);
      irq_in = '0;
      tick(3);

      // Asynchronous reset during service
      wr(2'd0, 32'h0);
      wr(2'd1, 32'h01);
      irq_in[0] = 1'b1;
      tick(3);
      take();
      rd_chk("svc_stat", 2'd3, 32'h0002_0101);
      reset = 1'b0;
      #1;
      chk("arst_hw", 32'(hw_int), 32'h0);
      rd_chk("arst_mode", 2'd0, 32'h0);
      rd_chk("arst_mask", 2'd1, 32'h0);
      rd_chk("arst_pend", 2'd2, 32'h0);
      rd_chk("arst_stat", 2'd3, 32'h0);
      irq_in = '0;
      @(negedge clk);
      reset = 1'b1;
      tick(1);
      take();
      chk("take_after_rst_hw", 32'(hw_int), 32'h0);
      rd_chk("take_after_rst_stat", 2'd3, 32'h0);

      // Randomized traffic, checked each cycle by the compare process
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ (6'($urandom) & 6'($urandom));
         we       = ($urandom_range(0, 4) == 0);
         addr     = 2'($urandom);
         wdata    = $urandom;
         int_take = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 299) == 0) begin
            #1;
            reset = 1'b0;
            #2;
            reset = 1'b1;
         end
         tick(1);
      end
      we       = 1'b0;
      int_take = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
